// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one synchronous memory between fetch and data ports
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_wmask,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win;

  // Byte-offset bits never reach the memory; the requester owns alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    win       = 1'b0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = 32'd0;
    d_rdata   = 32'd0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wmask = 4'd0;
    mem_wdata = 32'd0;
    // Every output is gated by reset so nothing leaks out while it is held.
    if (reset) begin
      if (state_q == IDLE) begin
        if (i_req || d_req) begin
          // win: 0 = fetch, 1 = data; on contention the port not served last wins.
          win       = (i_req && d_req) ? ~last_q : d_req;
          i_gnt     = ~win;
          d_gnt     = win;
          mem_en    = 1'b1;
          mem_addr  = win ? {d_addr[ADDR_WIDTH-1:2], 2'b00}
                          : {i_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wmask = win ? d_wmask : 4'd0;
          mem_wdata = win ? d_wdata : 32'd0;
          state_d   = WAIT;
          cnt_d     = '0;
          owner_d   = win;
          last_d    = win;
        end
      end else begin
        if (cnt_q == CNT_LAST) begin
          i_rvalid = ~owner_q;
          d_rvalid = owner_q;
          i_rdata  = owner_q ? 32'd0 : mem_rdata;
          d_rdata  = owner_q ? mem_rdata : 32'd0;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at read latencies 1, 3 and 2
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  logic mon_on = 1'b0;

  typedef struct {
    logic        port;
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[3][$];

  // ---------------- DUT A: RD_LATENCY = 1, backed by a small RAM model
  logic        rst_a = 1'b0, i_req_a = 1'b0, d_req_a = 1'b0;
  logic [15:0] i_addr_a = '0, d_addr_a = '0;
  logic [3:0]  d_wmask_a = '0;
  logic [31:0] d_wdata_a = '0;
  logic        i_gnt_a, i_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a;
  logic [31:0] i_rdata_a, d_rdata_a, mem_wdata_a, mem_rdata_a, rd_a;
  logic [15:0] mem_addr_a;
  logic [3:0]  mem_wmask_a;
  logic [31:0] ram [0:255];

  mem_port_arbiter #(.ADDR_WIDTH(16), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset(rst_a),
    .i_req(i_req_a), .i_addr(i_addr_a), .i_gnt(i_gnt_a), .i_rvalid(i_rvalid_a), .i_rdata(i_rdata_a),
    .d_req(d_req_a), .d_addr(d_addr_a), .d_wmask(d_wmask_a), .d_wdata(d_wdata_a),
    .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
    .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_wmask(mem_wmask_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  always @(posedge clk) begin
    if (!rst_a) begin
      for (int w = 0; w < 256; w++) ram[w] <= 32'h1000_0000 + w;
    end else if (mem_en_a) begin
      rd_a <= ram[mem_addr_a[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask_a[b]) ram[mem_addr_a[9:2]][8*b +: 8] <= mem_wdata_a[8*b +: 8];
    end
  end
  assign mem_rdata_a = rd_a;

  // ---------------- DUTs B (RD_LATENCY = 3) and C (RD_LATENCY = 2): memory returns a cycle tag
  function automatic logic [31:0] tag(input int c);
    return 32'hC0DE_0000 | (c & 32'h0000_FFFF);
  endfunction

  logic        rst_b = 1'b0, i_req_b = 1'b0, d_req_b = 1'b0;
  logic [15:0] i_addr_b = '0, d_addr_b = '0;
  logic        i_gnt_b, i_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b;
  logic [31:0] i_rdata_b, d_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [15:0] mem_addr_b;
  logic [3:0]  mem_wmask_b;
  assign mem_rdata_b = tag(cyc);

  mem_port_arbiter #(.ADDR_WIDTH(16), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(rst_b),
    .i_req(i_req_b), .i_addr(i_addr_b), .i_gnt(i_gnt_b), .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b),
    .d_req(d_req_b), .d_addr(d_addr_b), .d_wmask(4'd0), .d_wdata(32'd0),
    .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
    .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_wmask(mem_wmask_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  logic        rst_c = 1'b0, i_req_c = 1'b0, d_req_c = 1'b0;
  logic [15:0] i_addr_c = '0, d_addr_c = '0;
  logic        i_gnt_c, i_rvalid_c, d_gnt_c, d_rvalid_c, mem_en_c;
  logic [31:0] i_rdata_c, d_rdata_c, mem_wdata_c, mem_rdata_c;
  logic [15:0] mem_addr_c;
  logic [3:0]  mem_wmask_c;
  assign mem_rdata_c = tag(cyc);

  mem_port_arbiter #(.ADDR_WIDTH(16), .RD_LATENCY(2)) dut_c (
    .clk(clk), .reset(rst_c),
    .i_req(i_req_c), .i_addr(i_addr_c), .i_gnt(i_gnt_c), .i_rvalid(i_rvalid_c), .i_rdata(i_rdata_c),
    .d_req(d_req_c), .d_addr(d_addr_c), .d_wmask(4'd0), .d_wdata(32'd0),
    .d_gnt(d_gnt_c), .d_rvalid(d_rvalid_c), .d_rdata(d_rdata_c),
    .mem_en(mem_en_c), .mem_addr(mem_addr_c), .mem_wmask(mem_wmask_c),
    .mem_wdata(mem_wdata_c), .mem_rdata(mem_rdata_c)
  );

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int id, input logic port, input int c, input logic [31:0] d);
    exp_t e;
    e.port = port;
    e.cyc  = c;
    e.data = d;
    sbq[id].push_back(e);
  endtask

  task automatic mon(input int id, input logic iv, input logic dv,
                     input logic [31:0] ir, input logic [31:0] dr);
    exp_t e;
    string s;
    s = $sformatf("dut%0d", id);
    chk({s, " rvalid_both"}, 64'(iv && dv), 64'd0);
    if (iv || dv) begin
      if (sbq[id].size() == 0) begin
        chk({s, " unexpected_rvalid"}, 64'({iv, dv}), 64'd0);
      end else begin
        e = sbq[id].pop_front();
        chk({s, " rvalid_port"}, 64'(dv), 64'(e.port));
        chk({s, " rvalid_cycle"}, 64'(cyc), 64'(e.cyc));
        chk({s, " rdata"}, 64'(dv ? dr : ir), 64'(e.data));
      end
    end
    if (!iv) chk({s, " i_rdata_idle_zero"}, 64'(ir), 64'd0);
    if (!dv) chk({s, " d_rdata_idle_zero"}, 64'(dr), 64'd0);
  endtask

  always @(negedge clk) if (mon_on) mon(0, i_rvalid_a, d_rvalid_a, i_rdata_a, d_rdata_a);
  always @(negedge clk) if (mon_on) mon(1, i_rvalid_b, d_rvalid_b, i_rdata_b, d_rdata_b);
  always @(negedge clk) if (mon_on) mon(2, i_rvalid_c, d_rvalid_c, i_rdata_c, d_rdata_c);

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet_a(input string name);
    chk(name, {i_gnt_a, d_gnt_a, i_rvalid_a, d_rvalid_a, mem_en_a, mem_addr_a, mem_wmask_a}, 64'd0);
    chk({name, "_data"}, {mem_wdata_a, i_rdata_a | d_rdata_a}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [5:0] pat_i, pat_d;

  initial begin
    // Reset held with a request pending: nothing may leak out.
    next();
    i_req_a = 1'b1;
    i_addr_a = 16'h0012;
    @(negedge clk);
    chk_quiet_a("reset_outputs");
    next();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    mon_on = 1'b1;

    // Fetch read of 0x0012 at latency 1.
    @(negedge clk);
    chk("t1 i_gnt", 64'(i_gnt_a), 64'd1);
    chk("t1 d_gnt", 64'(d_gnt_a), 64'd0);
    chk("t1 mem_en", 64'(mem_en_a), 64'd1);
    chk("t1 mem_addr", 64'(mem_addr_a), 64'h0010);
    chk("t1 mem_wmask", 64'(mem_wmask_a), 64'd0);
    chk("t1 mem_wdata", 64'(mem_wdata_a), 64'd0);
    push(0, 1'b0, cyc + 1, 32'h1000_0004);
    next();
    i_req_a = 1'b0;
    @(negedge clk);
    chk("t1 no_grant_in_wait", 64'({i_gnt_a, d_gnt_a, mem_en_a}), 64'd0);
    next();

    // Re-reset so last = data, then hold both requests: strict alternation.
    rst_a = 1'b0;
    i_req_a = 1'b1;
    i_addr_a = 16'h0004;
    d_req_a = 1'b1;
    d_addr_a = 16'h0008;
    d_wmask_a = 4'd0;
    @(negedge clk);
    chk_quiet_a("reset2_outputs");
    next();
    rst_a = 1'b1;
    pat_i = 6'b010001;
    pat_d = 6'b000100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t2 i_gnt k%0d", k), 64'(i_gnt_a), 64'(pat_i[k]));
      chk($sformatf("t2 d_gnt k%0d", k), 64'(d_gnt_a), 64'(pat_d[k]));
      if (pat_i[k]) push(0, 1'b0, cyc + 1, 32'h1000_0001);
      if (pat_d[k]) push(0, 1'b1, cyc + 1, 32'h1000_0002);
      next();
    end
    i_req_a = 1'b0;
    d_req_a = 1'b0;
    next();

    // Partial store to 0x0022, then read the word back through the fetch port.
    d_req_a = 1'b1;
    d_addr_a = 16'h0022;
    d_wmask_a = 4'b1100;
    d_wdata_a = 32'hABCD_0000;
    @(negedge clk);
    chk("t3 d_gnt", 64'(d_gnt_a), 64'd1);
    chk("t3 mem_addr", 64'(mem_addr_a), 64'h0020);
    chk("t3 mem_wmask", 64'(mem_wmask_a), 64'b1100);
    chk("t3 mem_wdata", 64'(mem_wdata_a), 64'hABCD_0000);
    push(0, 1'b1, cyc + 1, 32'h1000_0008);
    next();
    d_req_a = 1'b0;
    d_wmask_a = 4'd0;
    d_wdata_a = 32'd0;
    next();
    i_req_a = 1'b1;
    i_addr_a = 16'h0020;
    @(negedge clk);
    chk("t3 readback i_gnt", 64'(i_gnt_a), 64'd1);
    push(0, 1'b0, cyc + 1, 32'hABCD_0008);
    next();
    i_req_a = 1'b0;
    next();

    // Fetch request withdrawn while data owns the memory: never granted.
    d_req_a = 1'b1;
    d_addr_a = 16'h0030;
    @(negedge clk);
    chk("t4 d_gnt", 64'(d_gnt_a), 64'd1);
    push(0, 1'b1, cyc + 1, 32'h1000_000C);
    next();
    d_req_a = 1'b0;
    i_req_a = 1'b1;
    i_addr_a = 16'h0044;
    @(negedge clk);
    chk("t4 i_gnt_in_wait", 64'(i_gnt_a), 64'd0);
    next();
    i_req_a = 1'b0;
    @(negedge clk);
    chk("t4 idle_quiet", 64'({i_gnt_a, d_gnt_a, mem_en_a, mem_addr_a}), 64'd0);
    next();

    // Latency 3 with a fetch request held continuously.
    i_req_b = 1'b1;
    i_addr_b = 16'h0100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("t5 i_gnt k%0d", k), 64'(i_gnt_b), 64'((k % 4) == 0));
      chk($sformatf("t5 mem_en k%0d", k), 64'(mem_en_b), 64'((k % 4) == 0));
      if ((k % 4) == 0) begin
        chk($sformatf("t5 mem_addr k%0d", k), 64'(mem_addr_b), 64'h0100);
        push(1, 1'b0, cyc + 3, tag(cyc + 3));
      end
      next();
    end
    i_req_b = 1'b0;
    next();

    // Latency 2: reset in the first WAIT cycle drops the pending response.
    d_req_c = 1'b1;
    d_addr_c = 16'h0040;
    @(negedge clk);
    chk("t6 d_gnt", 64'(d_gnt_c), 64'd1);
    next();
    rst_c = 1'b0;
    @(negedge clk);
    chk("t6 reset_outputs",
        {i_gnt_c, d_gnt_c, i_rvalid_c, d_rvalid_c, mem_en_c, mem_addr_c, mem_wmask_c}, 64'd0);
    chk("t6 reset_data", {mem_wdata_c, i_rdata_c | d_rdata_c}, 64'd0);
    next();
    rst_c = 1'b1;
    @(negedge clk);
    chk("t6 no_rvalid_after_reset", 64'(d_rvalid_c), 64'd0);
    chk("t6 regrant_first_cycle", 64'(d_gnt_c), 64'd1);
    chk("t6 regrant_mem_addr", 64'(mem_addr_c), 64'h0040);
    push(2, 1'b1, cyc + 2, tag(cyc + 2));
    next();
    d_req_c = 1'b0;

    repeat (6) next();
    for (int id = 0; id < 3; id++)
      chk($sformatf("dut%0d scoreboard_drained", id), 64'(sbq[id].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
